// File: rtl/ble_cfg_pkg.sv
// Shared definitions for the BLE configuration loader: FSM state codes,
// width helpers and the per-bit strobe group mask.
package ble_cfg_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_WORD = 3'd1;
  localparam logic [STATE_W-1:0] ST_SETUP     = 3'd2;
  localparam logic [STATE_W-1:0] ST_PULSE     = 3'd3;
  localparam logic [STATE_W-1:0] ST_HOLD      = 3'd4;
  localparam logic [STATE_W-1:0] ST_FINISH    = 3'd5;

  // Integer ceiling division, used to size the number of words per load.
  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  // Register width needed to count 0..v-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  // One bit of the group mask: bit bitIdx belongs to word wordIdx when it
  // falls in that word's DATA_SIZE-wide slice and exists in the SRAM.
  function automatic logic group_mask(input int unsigned wordIdx,
                                      input int unsigned bitIdx,
                                      input int unsigned dataSize,
                                      input int unsigned strobeSize);
    return (bitIdx < strobeSize) && ((bitIdx / dataSize) == wordIdx);
  endfunction

endpackage

// File: rtl/ble_strobe_decoder.sv
// Maps the current word index to the strobe group it drives. Purely
// combinational; the parent registers the result.
module ble_strobe_decoder
  import ble_cfg_pkg::*;
#(
  parameter int DATA_SIZE   = 8,
  parameter int STROBE_SIZE = 17,
  parameter int IDX_W       = 2
) (
  input  logic [IDX_W-1:0]       word_idx_i,
  input  logic                   enable_i,
  output logic [STROBE_SIZE-1:0] strobe_o
);

  // Build the clipped group mask bit by bit, gated by the enable.
  always_comb begin
    strobe_o = '0;
    for (int unsigned b = 0; b < STROBE_SIZE; b++) begin
      strobe_o[b] = enable_i && group_mask(32'(word_idx_i), b, DATA_SIZE, STROBE_SIZE);
    end
  end

endmodule

// File: rtl/ble_config_loader.sv
// Sequences the configuration SRAM load of one BLE: accepts words over a
// valid/ready stream and pulses one strobe group per word with fixed
// setup, pulse and hold timing. All outputs come straight from registers.
module ble_config_loader
  import ble_cfg_pkg::*;
#(
  parameter int DATA_SIZE    = 8,
  parameter int STROBE_SIZE  = 17,
  parameter int PULSE_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [DATA_SIZE-1:0]   in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [DATA_SIZE-1:0]   data_o,
  output logic [STROBE_SIZE-1:0] strobe_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int NUM_WORDS = int'(ceil_div(STROBE_SIZE, DATA_SIZE));
  localparam int IDX_W     = int'(clog2_min1(NUM_WORDS));
  localparam int CNT_W     = int'(clog2_min1(PULSE_CYCLES));

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PULSE_CYCLES - 1);

  logic [STATE_W-1:0]     state_q, state_d;
  logic [IDX_W-1:0]       wordIdx_q, wordIdx_d;
  logic [CNT_W-1:0]       pulseCnt_q, pulseCnt_d;
  logic [DATA_SIZE-1:0]   data_q, data_d;
  logic [STROBE_SIZE-1:0] strobe_q, strobe_d;
  logic                   inReady_q, busy_q, done_q;
  logic                   pulseNext;

  // Next-state logic; abort overrides every state and returns to idle.
  always_comb begin
    state_d    = state_q;
    wordIdx_d  = wordIdx_q;
    pulseCnt_d = pulseCnt_q;
    data_d     = data_q;
    if (abort_i) begin
      state_d    = ST_IDLE;
      wordIdx_d  = '0;
      pulseCnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d   = ST_WAIT_WORD;
            wordIdx_d = '0;
          end
        end
        ST_WAIT_WORD: begin
          if (in_valid_i) begin
            data_d  = in_data_i;
            state_d = ST_SETUP;
          end
        end
        ST_SETUP: begin
          state_d    = ST_PULSE;
          pulseCnt_d = '0;
        end
        ST_PULSE: begin
          if (pulseCnt_q == LAST_CNT) begin
            state_d    = ST_HOLD;
            pulseCnt_d = '0;
          end else begin
            pulseCnt_d = pulseCnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (wordIdx_q == LAST_IDX) begin
            state_d = ST_FINISH;
          end else begin
            wordIdx_d = wordIdx_q + 1'b1;
            state_d   = ST_WAIT_WORD;
          end
        end
        ST_FINISH: begin
          state_d   = ST_IDLE;
          wordIdx_d = '0;
        end
        default: begin
          state_d   = ST_IDLE;
          wordIdx_d = '0;
        end
      endcase
    end
  end

  assign pulseNext = (state_d == ST_PULSE);

  ble_strobe_decoder #(
    .DATA_SIZE   (DATA_SIZE),
    .STROBE_SIZE (STROBE_SIZE),
    .IDX_W       (IDX_W)
  ) u_strobe_decoder (
    .word_idx_i (wordIdx_d),
    .enable_i   (pulseNext),
    .strobe_o   (strobe_d)
  );

  // State, counters and output flags are all registered from next-state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      wordIdx_q  <= '0;
      pulseCnt_q <= '0;
      data_q     <= '0;
      strobe_q   <= '0;
      inReady_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wordIdx_q  <= wordIdx_d;
      pulseCnt_q <= pulseCnt_d;
      data_q     <= data_d;
      strobe_q   <= strobe_d;
      inReady_q  <= (state_d == ST_WAIT_WORD);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_FINISH);
    end
  end

  assign in_ready_o = inReady_q;
  assign data_o     = data_q;
  assign strobe_o   = strobe_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_ble_config_loader.sv
// Directed bench for ble_config_loader: default instance plus three
// parameter variants sharing the data/valid/abort/reset stimulus.
module tb_ble_config_loader;

  logic clk = 1'b0;
  logic rstN, startMain, start8, start4, startP1, abort, validIn;
  logic [7:0] dataIn;
  logic [3:0] dataIn4;

  logic readyM, busyM, doneM;
  logic [7:0] dataM;
  logic [16:0] strobeM;
  logic ready8, busy8, done8;
  logic [7:0] data8, strobe8;
  logic ready4, busy4, done4;
  logic [3:0] data4;
  logic [16:0] strobe4;
  logic readyP1, busyP1, doneP1;
  logic [7:0] dataP1;
  logic [16:0] strobeP1;

  int testsRun = 0;
  int testsFailed = 0;
  logic [7:0] prevDataM = 8'h00;
  logic [3:0] prevData4 = 4'h0;

  always #5 clk = ~clk;

  ble_config_loader dut (
    .clk_i(clk), .rst_ni(rstN), .start_i(startMain), .abort_i(abort),
    .in_data_i(dataIn), .in_valid_i(validIn), .in_ready_o(readyM),
    .data_o(dataM), .strobe_o(strobeM), .busy_o(busyM), .done_o(doneM)
  );

  ble_config_loader #(.DATA_SIZE(8), .STROBE_SIZE(8), .PULSE_CYCLES(2)) dut8 (
    .clk_i(clk), .rst_ni(rstN), .start_i(start8), .abort_i(abort),
    .in_data_i(dataIn), .in_valid_i(validIn), .in_ready_o(ready8),
    .data_o(data8), .strobe_o(strobe8), .busy_o(busy8), .done_o(done8)
  );

  ble_config_loader #(.DATA_SIZE(4), .STROBE_SIZE(17), .PULSE_CYCLES(2)) dut4 (
    .clk_i(clk), .rst_ni(rstN), .start_i(start4), .abort_i(abort),
    .in_data_i(dataIn4), .in_valid_i(validIn), .in_ready_o(ready4),
    .data_o(data4), .strobe_o(strobe4), .busy_o(busy4), .done_o(done4)
  );

  ble_config_loader #(.DATA_SIZE(8), .STROBE_SIZE(17), .PULSE_CYCLES(1)) dutP1 (
    .clk_i(clk), .rst_ni(rstN), .start_i(startP1), .abort_i(abort),
    .in_data_i(dataIn), .in_valid_i(validIn), .in_ready_o(readyP1),
    .data_o(dataP1), .strobe_o(strobeP1), .busy_o(busyP1), .done_o(doneP1)
  );

  // Whenever a strobe is active it must be exactly one group and DATA must
  // not have moved since the previous cycle.
  always @(negedge clk) begin
    if (rstN === 1'b1 && strobeM !== 17'h0) begin
      testsRun++;
      if (dataM !== prevDataM || !(strobeM inside {17'h000FF, 17'h0FF00, 17'h10000})) begin
        testsFailed++;
        $display("[TB] FAIL monitor_main: strobe %h data %h, required one group with data held at %h",
                 strobeM, dataM, prevDataM);
      end
    end
    if (rstN === 1'b1 && strobe4 !== 17'h0) begin
      testsRun++;
      if (data4 !== prevData4 ||
          !(strobe4 inside {17'h0000F, 17'h000F0, 17'h00F00, 17'h0F000, 17'h10000})) begin
        testsFailed++;
        $display("[TB] FAIL monitor_d4: strobe %h data %h, required one group with data held at %h",
                 strobe4, data4, prevData4);
      end
    end
    prevDataM = dataM;
    prevData4 = data4;
  end

  task test_reset();
    rstN = 1'b0; startMain = 1'b0; start8 = 1'b0; start4 = 1'b0; startP1 = 1'b0;
    abort = 1'b0; validIn = 1'b0; dataIn = 8'h00; dataIn4 = 4'h0;
    repeat (2) @(negedge clk);
    testsRun++;
    if ({readyM, busyM, doneM, strobeM, dataM} !== 28'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: got %h required 0", {readyM, busyM, doneM, strobeM, dataM});
    end
    rstN = 1'b1;
    @(negedge clk);
    startMain = 1'b1; validIn = 1'b1; dataIn = 8'h5A;
    @(negedge clk);
    startMain = 1'b0;
    repeat (2) @(negedge clk);
    testsRun++;
    if (strobeM !== 17'h000FF) begin
      testsFailed++;
      $display("[TB] FAIL reset_prepulse: strobe %h required 000ff", strobeM);
    end
    #2 rstN = 1'b0;
    #1;
    testsRun++;
    if ({readyM, busyM, strobeM} !== 19'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_async: ready/busy/strobe %h required 0", {readyM, busyM, strobeM});
    end
    validIn = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    testsRun++;
    if ({readyM, busyM, doneM, dataM} !== 11'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_release: ready/busy/done/data %h required 0", {readyM, busyM, doneM, dataM});
    end
  endtask

  task test_full_load();
    logic [2:0] expFlags;
    logic [16:0] expStrobe;
    logic [7:0] expData;
    startMain = 1'b1; validIn = 1'b1; dataIn = 8'hA5;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      startMain = 1'b0;
      expFlags = (c == 0 || c == 5 || c == 10) ? 3'b110 :
                 (c == 15) ? 3'b011 : (c == 16) ? 3'b000 : 3'b010;
      case (c)
        2, 3:    expStrobe = 17'h000FF;
        7, 8:    expStrobe = 17'h0FF00;
        12, 13:  expStrobe = 17'h10000;
        default: expStrobe = 17'h0;
      endcase
      expData = (c == 0) ? 8'h00 : (c <= 5) ? 8'hA5 : (c <= 10) ? 8'h3C : 8'h01;
      testsRun++;
      if ({readyM, busyM, doneM} !== expFlags) begin
        testsFailed++;
        $display("[TB] FAIL full_load_flags c%0d: rdy/busy/done %b required %b", c, {readyM, busyM, doneM}, expFlags);
      end
      testsRun++;
      if (strobeM !== expStrobe) begin
        testsFailed++;
        $display("[TB] FAIL full_load_strobe c%0d: %h required %h", c, strobeM, expStrobe);
      end
      testsRun++;
      if (dataM !== expData) begin
        testsFailed++;
        $display("[TB] FAIL full_load_data c%0d: %h required %h", c, dataM, expData);
      end
      dataIn = (c < 1) ? 8'hA5 : (c < 6) ? 8'h3C : 8'h01;
    end
    validIn = 1'b0;
  endtask

  task test_stall();
    logic [2:0] expFlags;
    logic [16:0] expStrobe;
    logic [7:0] expData;
    startMain = 1'b1; validIn = 1'b1; dataIn = 8'h11;
    for (int c = 0; c <= 21; c++) begin
      @(negedge clk);
      startMain = 1'b0;
      expFlags = {(c == 0 || (c >= 5 && c <= 10) || c == 15), (c <= 20), (c == 20)};
      case (c)
        2, 3:    expStrobe = 17'h000FF;
        12, 13:  expStrobe = 17'h0FF00;
        17, 18:  expStrobe = 17'h10000;
        default: expStrobe = 17'h0;
      endcase
      expData = (c == 0) ? 8'h01 : (c <= 10) ? 8'h11 : (c <= 15) ? 8'h22 : 8'h33;
      testsRun++;
      if ({readyM, busyM, doneM} !== expFlags) begin
        testsFailed++;
        $display("[TB] FAIL stall_flags c%0d: rdy/busy/done %b required %b", c, {readyM, busyM, doneM}, expFlags);
      end
      testsRun++;
      if (strobeM !== expStrobe || dataM !== expData) begin
        testsFailed++;
        $display("[TB] FAIL stall_strobe_data c%0d: %h/%h required %h/%h", c, strobeM, dataM, expStrobe, expData);
      end
      validIn = (c == 0 || c >= 10);
      dataIn = (c == 0) ? 8'h11 : (c <= 10) ? 8'h22 : 8'h33;
    end
    validIn = 1'b0;
  endtask

  task test_abort();
    startMain = 1'b1; validIn = 1'b1; dataIn = 8'h5A;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      startMain = 1'b0;
      dataIn = 8'hC3;
    end
    testsRun++;
    if (strobeM !== 17'h0FF00 || dataM !== 8'hC3) begin
      testsFailed++;
      $display("[TB] FAIL abort_prepulse: strobe/data %h/%h required 0ff00/c3", strobeM, dataM);
    end
    abort = 1'b1; validIn = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    testsRun++;
    if ({readyM, busyM, doneM, strobeM, dataM} !== {3'b000, 17'h0, 8'hC3}) begin
      testsFailed++;
      $display("[TB] FAIL abort_clear: rdy/busy/done/strobe/data %h required %h",
               {readyM, busyM, doneM, strobeM, dataM}, {3'b000, 17'h0, 8'hC3});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      testsRun++;
      if ({busyM, doneM} !== 2'b00) begin
        testsFailed++;
        $display("[TB] FAIL abort_no_done c%0d: busy/done %b required 00", c, {busyM, doneM});
      end
    end
    startMain = 1'b1; validIn = 1'b1; dataIn = 8'h77;
    @(negedge clk);
    startMain = 1'b0;
    testsRun++;
    if (readyM !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL abort_restart_ready: %b required 1", readyM);
    end
    repeat (2) @(negedge clk);
    testsRun++;
    if (strobeM !== 17'h000FF || dataM !== 8'h77) begin
      testsFailed++;
      $display("[TB] FAIL abort_restart_word0: strobe/data %h/%h required 000ff/77", strobeM, dataM);
    end
    abort = 1'b1; validIn = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    testsRun++;
    if (busyM !== 1'b0 || strobeM !== 17'h0) begin
      testsFailed++;
      $display("[TB] FAIL abort_cleanup: busy/strobe %b/%h required 0/0", busyM, strobeM);
    end
  endtask

  task test_start_ignored();
    startMain = 1'b1; abort = 1'b1;
    @(negedge clk);
    startMain = 1'b0; abort = 1'b0;
    testsRun++;
    if ({readyM, busyM} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL start_abort_idle: rdy/busy %b required 00", {readyM, busyM});
    end
    @(negedge clk);
    startMain = 1'b1; validIn = 1'b1; dataIn = 8'h0F;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      startMain = (c >= 1 && c <= 3) || c == 15;
      dataIn = (c < 1) ? 8'h0F : (c < 6) ? 8'hF0 : 8'hAA;
      if (c == 2 || c == 7 || c == 12) begin
        testsRun++;
        if ({strobeM, dataM} !== ((c == 2) ? {17'h000FF, 8'h0F} :
                                  (c == 7) ? {17'h0FF00, 8'hF0} : {17'h10000, 8'hAA})) begin
          testsFailed++;
          $display("[TB] FAIL start_busy_pulse c%0d: strobe/data %h", c, {strobeM, dataM});
        end
      end
      if (c == 15) begin
        testsRun++;
        if ({busyM, doneM} !== 2'b11) begin
          testsFailed++;
          $display("[TB] FAIL start_busy_done: busy/done %b required 11", {busyM, doneM});
        end
      end
      if (c >= 16) begin
        testsRun++;
        if ({readyM, busyM} !== 2'b00) begin
          testsFailed++;
          $display("[TB] FAIL start_busy_idle c%0d: rdy/busy %b required 00", c, {readyM, busyM});
        end
      end
    end
    startMain = 1'b0; validIn = 1'b0;
  endtask

  task test_sweep_single_word();
    start8 = 1'b1; validIn = 1'b1; dataIn = 8'h96;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (c == 0) begin
        testsRun++;
        if (ready8 !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL d8s8_ready: %b required 1", ready8);
        end
      end
      if (c == 2 || c == 3) begin
        testsRun++;
        if (strobe8 !== 8'hFF || data8 !== 8'h96) begin
          testsFailed++;
          $display("[TB] FAIL d8s8_mask c%0d: strobe/data %h/%h required ff/96", c, strobe8, data8);
        end
      end
      if (c == 4 || c == 5 || c == 6) begin
        testsRun++;
        if ({strobe8, busy8, done8} !== {8'h00, (c != 6), (c == 5)}) begin
          testsFailed++;
          $display("[TB] FAIL d8s8_end c%0d: strobe/busy/done %h", c, {strobe8, busy8, done8});
        end
      end
    end
    validIn = 1'b0;
  endtask

  task test_sweep_narrow_data();
    logic [16:0] masks [5];
    masks = '{17'h0000F, 17'h000F0, 17'h00F00, 17'h0F000, 17'h10000};
    start4 = 1'b1; validIn = 1'b1; dataIn4 = 4'h9;
    for (int c = 0; c <= 26; c++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (c <= 24 && (c % 5) == 2) begin
        testsRun++;
        if (strobe4 !== masks[c / 5] || data4 !== 4'h9) begin
          testsFailed++;
          $display("[TB] FAIL d4s17_mask c%0d: strobe/data %h/%h required %h/9", c, strobe4, data4, masks[c / 5]);
        end
      end
      if (c <= 24 && (c % 5) == 0) begin
        testsRun++;
        if (ready4 !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL d4s17_ready c%0d: %b required 1", c, ready4);
        end
      end
      if (c >= 25) begin
        testsRun++;
        if ({busy4, done4} !== ((c == 25) ? 2'b11 : 2'b00)) begin
          testsFailed++;
          $display("[TB] FAIL d4s17_end c%0d: busy/done %b", c, {busy4, done4});
        end
      end
    end
    validIn = 1'b0;
  endtask

  task test_sweep_short_pulse();
    logic [16:0] masks [3];
    masks = '{17'h000FF, 17'h0FF00, 17'h10000};
    startP1 = 1'b1; validIn = 1'b1; dataIn = 8'h96;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      startP1 = 1'b0;
      if (c <= 11 && (c % 4) == 2) begin
        testsRun++;
        if (strobeP1 !== masks[c / 4] || dataP1 !== 8'h96) begin
          testsFailed++;
          $display("[TB] FAIL p1_pulse c%0d: strobe/data %h/%h required %h/96", c, strobeP1, dataP1, masks[c / 4]);
        end
      end
      if (c <= 11 && (c % 4) == 3) begin
        testsRun++;
        if (strobeP1 !== 17'h0) begin
          testsFailed++;
          $display("[TB] FAIL p1_hold c%0d: strobe %h required 0", c, strobeP1);
        end
      end
      if (c == 4 || c == 8) begin
        testsRun++;
        if (readyP1 !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL p1_ready c%0d: %b required 1", c, readyP1);
        end
      end
      if (c >= 12) begin
        testsRun++;
        if ({busyP1, doneP1} !== ((c == 12) ? 2'b11 : 2'b00)) begin
          testsFailed++;
          $display("[TB] FAIL p1_end c%0d: busy/done %b", c, {busyP1, doneP1});
        end
      end
    end
    validIn = 1'b0;
  endtask

  // Guard against a hang; fixed-length tasks never need this in practice.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_abort();
    test_start_ignored();
    test_sweep_single_word();
    test_sweep_narrow_data();
    test_sweep_short_pulse();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ble_config_loader.md
Name: ble_config_loader

Overview:
Sequences the configuration SRAM load of one bleGeneric-style logic element. It accepts configuration words over a valid/ready stream and drives the element's shared DATA bus and per-cell STROBE lines. It loads ceil(STROBE_SIZE/DATA_SIZE) words, one strobe group at a time, with guaranteed setup, pulse and hold timing. It sits between the fabric configuration controller and each BLE instance.

Parameters:
DATA_SIZE, 8, width of the config word bus; equals the BLE DATA width.
STROBE_SIZE, 17, number of SRAM cells; equals the BLE STROBE width (NB_INPUTS**2+1).
PULSE_CYCLES, 2, strobe high time in CLK cycles; must be >= 1.
NUM_WORDS (localparam), ceil(STROBE_SIZE/DATA_SIZE) = 3, words per load.

Ports:
CLK  in  1  single clock; all logic is rising-edge.
RST_N  in  1  asynchronous active-low reset.
START  in  1  begin a load; sampled only in IDLE.
ABORT  in  1  cancel an in-progress load.
IN_DATA  in  DATA_SIZE  config word.
IN_VALID  in  1  IN_DATA valid.
IN_READY  out  1  loader accepts a word this cycle.
DATA  out  DATA_SIZE  to BLE DATA.
STROBE  out  STROBE_SIZE  to BLE STROBE; at most one group is active.
BUSY  out  1  load in progress (any state except IDLE).
DONE  out  1  one-cycle pulse after the last word's HOLD.

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; word_idx 0; pulse counter 0; DATA, STROBE, IN_READY, BUSY, DONE all 0.
- All outputs are decoded from registers only. There is no combinational path from inputs to outputs.
- FSM states: IDLE, WAIT_WORD, SETUP, PULSE, HOLD, FINISH.
- IDLE: if START and not ABORT, go to WAIT_WORD and set word_idx to 0. START in any other state is ignored.
- WAIT_WORD: IN_READY=1.
  - On IN_VALID&&IN_READY, register IN_DATA into DATA and go to SETUP.
  - With no valid word, stay in WAIT_WORD indefinitely.
- SETUP: 1 cycle. DATA is stable and STROBE is 0.
- PULSE: PULSE_CYCLES cycles. STROBE = group mask for word_idx:
  - the mask sets bits [word_idx*DATA_SIZE +: DATA_SIZE];
  - bits at or above STROBE_SIZE are clipped.
  - Default masks: word0 = bits 7..0, word1 = bits 15..8, word2 = bit 16 only.
- HOLD: 1 cycle. STROBE is 0 and DATA is unchanged.
  - If word_idx == NUM_WORDS-1, go to FINISH.
  - Otherwise increment word_idx and go to WAIT_WORD.
- FINISH: DONE=1 and BUSY=1 for one cycle, then IDLE.
- DATA keeps its last loaded value in IDLE. It changes only on a handshake.
- Per-word latency: handshake at edge T; SETUP in cycle T+1; PULSE in T+2..T+1+P; HOLD in T+2+P; IN_READY high again in T+3+P.
  - Back-to-back throughput is one word per P+3 cycles.
  - With P=2, a full load takes 15 cycles from the first IN_READY to FINISH.
- ABORT has priority over everything. In any state the next state is IDLE.
  - STROBE clears at that edge, with no DONE pulse and word_idx reset to 0.
  - Cells already strobed keep their new values.
- START and ABORT asserted together in IDLE leave the FSM in IDLE.
- Boundary: STROBE_SIZE % DATA_SIZE == 0 gives a full last group.
- Boundary: STROBE_SIZE <= DATA_SIZE gives NUM_WORDS=1 and mask bits [STROBE_SIZE-1:0]. Unused DATA bits are don't-care downstream.
- Width rules:
  - word_idx width is max(1, $clog2(NUM_WORDS)).
  - The pulse counter width is max(1, $clog2(PULSE_CYCLES)).
  - The mask is computed as a (NUM_WORDS*DATA_SIZE)-bit value, then truncated to STROBE_SIZE.

Decomposition:
- Package ble_cfg_pkg holds:
  - the state enum;
  - a ceil_div function;
  - the group_mask(word_idx, DATA_SIZE, STROBE_SIZE) function.
- One natural sub-module is ble_strobe_decoder. It maps word_idx plus an enable to the STROBE_SIZE mask and is registered in the parent.
- The FSM and counters remain in ble_config_loader.

Test Plan:
- Reset mid-PULSE with RST_N low: STROBE=0, BUSY=0 and IN_READY=0 immediately (asynchronous), and the FSM is in IDLE after release.
- Full load with defaults, P=2, IN_VALID held high, words 0xA5, 0x3C, 0x01:
  - STROBE=0x000FF for 2 cycles with DATA=0xA5;
  - then STROBE=0x0FF00 with DATA=0x3C;
  - then STROBE=0x10000 with DATA=0x01;
  - DONE pulses once, 15 cycles after the first IN_READY.
- Stall: IN_VALID low for 5 cycles before word1 leaves the FSM in WAIT_WORD with IN_READY=1 and STROBE=0, then it resumes with identical timing.
- ABORT asserted in PULSE of word1: STROBE=0 the next cycle, state IDLE, no DONE; a following START reloads from word0 (mask 0x000FF).
- START during BUSY is ignored; START+ABORT together in IDLE leaves BUSY=0.
- Parameter sweep:
  - DATA_SIZE=8, STROBE_SIZE=8 gives 1 word and mask 0xFF;
  - DATA_SIZE=4, STROBE_SIZE=17 gives 5 words with last mask 0x10000;
  - PULSE_CYCLES=1 gives 4 cycles per word.
- Assertion checks throughout:
  - STROBE is one-hot per group;
  - STROBE is never nonzero in the same cycle DATA changes.
